// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences CPU reset, run and stop (halt or cycle-budget timeout) with a run-cycle counter.
// Optional single-step clock enable (step_mode/step ports) when RUN_CTRL_SINGLE_STEP_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 30,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HALT_W     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HALT_W-1:0] halt_req,
`ifdef RUN_CTRL_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              cpu_reset,
    output logic              cpu_ce,
    output logic              run,
    output logic              done,
    output logic              timeout,
    output logic [HALT_W-1:0] halt_src,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned     RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state, state_nx;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_nx;
    logic [CNT_W-1:0]  cnt_nx;
    logic              timeout_nx;
    logic [HALT_W-1:0] halt_src_nx;
    logic              ce_nx;
    logic              step_ok;
    logic              budget_hit;

`ifdef RUN_CTRL_SINGLE_STEP_EN
    assign step_ok = !step_mode || step;
`else
    assign step_ok = 1'b1;
`endif

    assign budget_hit = (MAX_CYCLES != 0) && cpu_ce && (cycle_count == CNT_LAST);

    // Next-state and next-output logic; abort outranks every other request.
    always_comb begin
        state_nx    = state;
        rst_cnt_nx  = rst_cnt;
        cnt_nx      = cycle_count;
        timeout_nx  = timeout;
        halt_src_nx = halt_src;
        ce_nx       = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nx    = S_RESET;
                        rst_cnt_nx  = '0;
                        cnt_nx      = '0;
                        timeout_nx  = 1'b0;
                        halt_src_nx = '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RC_LAST) begin
                        state_nx = S_RUN;
                    end else begin
                        rst_cnt_nx = rst_cnt + RC_W'(1);
                    end
                end
                S_RUN: begin
                    if (cpu_ce && (cycle_count != CNT_MAX)) begin
                        cnt_nx = cycle_count + CNT_W'(1);
                    end
                    // A halt in the same cycle as budget expiry is reported as a halt.
                    if (|halt_req) begin
                        state_nx    = S_DONE;
                        halt_src_nx = halt_req;
                        timeout_nx  = 1'b0;
                    end else if (budget_hit) begin
                        state_nx   = S_DONE;
                        timeout_nx = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
        ce_nx = (state_nx == S_RUN) && step_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            halt_src    <= '0;
            cpu_reset   <= 1'b1;
            cpu_ce      <= 1'b0;
            run         <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            rst_cnt     <= rst_cnt_nx;
            cycle_count <= cnt_nx;
            timeout     <= timeout_nx;
            halt_src    <= halt_src_nx;
            cpu_reset   <= (state_nx != S_RUN);
            cpu_ce      <= ce_nx;
            run         <= (state_nx == S_RUN);
            done        <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: randomized runs scored against a transaction-level model via a result queue.
// Build with RUN_CTRL_SINGLE_STEP_EN defined to also exercise the single-step ports.
module tb_cpu_run_ctrl;

    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned MAX_CYCLES = 30;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned HALT_W     = 3;
    localparam int          MAXI       = 30;

    typedef struct packed {
        logic [HALT_W-1:0] src;
        logic              tmo;
        logic [CNT_W-1:0]  cnt;
    } result_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [HALT_W-1:0] halt_req = '0;
    logic              step_mode_tb = 1'b0;
    logic              step_tb = 1'b0;
    logic              cpu_reset, cpu_ce, run, done, timeout;
    logic [HALT_W-1:0] halt_src;
    logic [CNT_W-1:0]  cycle_count;

    logic              start_s = 1'b0;
    logic              abort_s = 1'b0;
    logic [0:0]        halt_s = 1'b0;
    logic              cpu_reset_s, cpu_ce_s, run_s, done_s, timeout_s;
    logic [0:0]        halt_src_s;
    logic [2:0]        cycle_count_s;

    result_t exp_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W), .HALT_W(HALT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .halt_req(halt_req),
`ifdef RUN_CTRL_SINGLE_STEP_EN
        .step_mode(step_mode_tb), .step(step_tb),
`endif
        .cpu_reset(cpu_reset), .cpu_ce(cpu_ce), .run(run), .done(done),
        .timeout(timeout), .halt_src(halt_src), .cycle_count(cycle_count)
    );

    // Narrow counter, timeout disabled: used to see the counter saturate.
    cpu_run_ctrl #(
        .RST_CYCLES(1), .MAX_CYCLES(0), .CNT_W(3), .HALT_W(1)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start_s), .abort(abort_s), .halt_req(halt_s),
`ifdef RUN_CTRL_SINGLE_STEP_EN
        .step_mode(1'b0), .step(1'b0),
`endif
        .cpu_reset(cpu_reset_s), .cpu_ce(cpu_ce_s), .run(run_s), .done(done_s),
        .timeout(timeout_s), .halt_src(halt_src_s), .cycle_count(cycle_count_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run outcome from the rules: halt raised during run cycle k (count==k) unless the budget ran out first.
    function automatic result_t predict(input int k, input logic [HALT_W-1:0] src);
        result_t r;
        if (k >= 0 && k <= MAXI - 1) begin
            r.src = src;
            r.tmo = 1'b0;
            r.cnt = CNT_W'(k + 1);
        end else begin
            r.src = '0;
            r.tmo = 1'b1;
            r.cnt = CNT_W'(MAXI);
        end
        return r;
    endfunction

    // Scoreboard monitor: each DONE entry is matched to the oldest expected run result.
    initial begin : monitor
        logic    done_q;
        result_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("halt_src", 32'(halt_src), 32'(e.src));
                    check("timeout", 32'(timeout), 32'(e.tmo));
                    check("cycle_count", 32'(cycle_count), 32'(e.cnt));
                end
            end
            done_q = done;
        end
    end

    always @(negedge clk) begin
        if (reset_n && !step_mode_tb)
            check("ce_reset_vs_run", 32'({cpu_reset, cpu_ce, run & done}), 32'({~run, run, 1'b0}));
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears_status", 32'({done, run, cpu_reset, timeout, halt_src, cycle_count}),
              32'({1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 16'd0}));
    endtask

    task automatic wait_run();
        int lat = 0;
        while (!run && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("reset_hold_cycles", 32'(lat), 32'(RST_CYCLES));
        check("count_at_run_entry", 32'(cycle_count), 32'(0));
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(done), 32'(1));
    endtask

    task automatic do_run(input int k, input logic [HALT_W-1:0] src, input bit poke_start);
        exp_q.push_back(predict(k, src));
        pulse_start();
        wait_run();
        if (poke_start) start = 1'b1;
        if (k >= 0 && k <= MAXI - 1) begin
            for (int i = 0; i < k; i++) begin
                @(negedge clk);
                start = 1'b0;
            end
            halt_req = src;
            @(negedge clk);
            halt_req = '0;
            start = 1'b0;
        end else if (poke_start) begin
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(MAXI + 8);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin : stim
        int ce_seen;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({cpu_reset, cpu_ce, run, done, timeout, halt_src, cycle_count}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0}));
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'({cpu_reset, run, done}), 32'(3'b100));

        do_run(-1, 3'b000, 1'b0);
        do_run(7, 3'b100, 1'b0);
        do_run(MAXI - 1, 3'b001, 1'b0);
        do_run(MAXI - 2, 3'b010, 1'b1);
        do_run(MAXI, 3'b111, 1'b0);
        do_run(0, 3'b011, 1'b1);
        for (int r = 0; r < 12; r++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, MAXI + 3));
            do_run(k, HALT_W'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
        end

        // start and abort together mid-run: abort wins and the count is kept.
        pulse_start();
        wait_run();
        repeat (5) @(negedge clk);
        check("count_before_abort", 32'(cycle_count), 32'(5));
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_to_idle", 32'({cpu_reset, cpu_ce, run, done, cycle_count}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 16'd5}));
        repeat (3) @(negedge clk);
        check("idle_holds_after_abort", 32'({cpu_reset, run, done, cycle_count}), 32'({3'b100, 16'd5}));
        do_run(3, 3'b101, 1'b0);

        // Asynchronous reset mid-run takes effect without a clock edge.
        pulse_start();
        wait_run();
        repeat (5) @(negedge clk);
        check("count_before_reset", 32'(cycle_count), 32'(5));
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({cpu_reset, cpu_ce, run, done, timeout, halt_src, cycle_count}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0}));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_holds_after_reset", 32'({cpu_reset, run, done, cycle_count}), 32'({3'b100, 16'd0}));

`ifdef RUN_CTRL_SINGLE_STEP_EN
        step_mode_tb = 1'b1;
        pulse_start();
        wait_run();
        ce_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (cpu_ce) ce_seen++;
            step_tb = (i == 1 || i == 5 || i == 9);
            @(negedge clk);
        end
        step_tb = 1'b0;
        check("step_ce_cycles", 32'(ce_seen), 32'(3));
        check("step_count", 32'(cycle_count), 32'(3));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        step_mode_tb = 1'b0;
        @(negedge clk);
`else
        ce_seen = 0;
`endif

        // Saturating counter with the timeout disabled.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (16) @(negedge clk);
        check("sat_count", 32'({run_s, done_s, cycle_count_s}), 32'({1'b1, 1'b0, 3'd7}));
        halt_s = 1'b1;
        @(negedge clk);
        halt_s = 1'b0;
        check("sat_halt", 32'({done_s, timeout_s, halt_src_s, cycle_count_s}),
              32'({1'b1, 1'b0, 1'b1, 3'd7}));

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: cycles the CPU reset is held after a run is started (min 1).
REQ-002 Parameter MAX_CYCLES, default 30: run-cycle budget; 0 disables the timeout.
REQ-003 Parameter CNT_W, default 16: width of the cycle counter.
REQ-004 Parameter HALT_W, default 1: number of independent halt-request channels.
REQ-005 Port clk  in  1  single clock; all state changes on rising edge.
REQ-006 Port reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port start  in  1  one-cycle request to begin a run.
REQ-008 Port abort  in  1  forces a return to IDLE from any state.
REQ-009 Port halt_req  in  HALT_W  per-channel halt request from the CPU/debug logic.
REQ-010 Port cpu_reset  out  1  active-high reset driven to the CPU.
REQ-011 Port cpu_ce  out  1  CPU clock enable.
REQ-012 Port run  out  1  high while in RUN.
REQ-013 Port done  out  1  high while in DONE.
REQ-014 Port timeout  out  1  high in DONE when the budget expired.
REQ-015 Port halt_src  out  HALT_W  halt channels latched at the stop.
REQ-016 Port cycle_count  out  CNT_W  count of enabled RUN cycles.

Function
REQ-017 The FSM SHALL have the states IDLE, RESET, RUN and DONE, all outputs registered.
REQ-018 IDLE: cpu_reset=1, cpu_ce=0 and run=0; start SHALL move the FSM to RESET and clear cycle_count, timeout and halt_src.
REQ-019 RESET: cpu_reset SHALL stay 1 for exactly RST_CYCLES cycles; the FSM SHALL then enter RUN.
REQ-020 RUN: cpu_reset=0, run=1 and cpu_ce=1; cycle_count SHALL increment on each cycle with cpu_ce=1 and saturate at all-ones.
REQ-021 RUN: if any halt_req bit is 1, the FSM SHALL enter DONE next cycle, latch halt_src=halt_req and set timeout=0.
REQ-022 RUN: if MAX_CYCLES!=0, halt_req==0 and cycle_count==MAX_CYCLES-1 with cpu_ce=1, the FSM SHALL enter DONE with timeout=1.
REQ-023 A halt and a budget expiry in the same cycle SHALL resolve as a halt (timeout=0).
REQ-024 DONE: done=1, cpu_reset=1 and cpu_ce=0; cycle_count, timeout and halt_src SHALL hold.
REQ-025 start in DONE SHALL restart via RESET with status cleared; start in RESET or RUN SHALL be ignored.
REQ-026 abort SHALL move the FSM to IDLE next cycle from any state, with priority over start, halt and timeout; status holds.
REQ-027 Moore outputs SHALL change only one cycle after the causing input.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, cpu_reset=1, cpu_ce=0, run=0, done=0, timeout=0, halt_src=0 and cycle_count=0, including mid-run.
REQ-029 After reset_n rises, the block SHALL stay in IDLE until start.

Configuration
REQ-030 Macro RUN_CTRL_SINGLE_STEP_EN SHALL, when defined, add the inputs step_mode and step.
REQ-031 With step_mode=1 in RUN, cpu_ce SHALL be 1 only in the cycle after a step pulse; the budget counts only those cycles.
REQ-032 Without the macro, the step_mode and step ports SHALL be absent and cpu_ce SHALL equal run.

Verification
REQ-033 Defaults; reset_n low 2 cycles, then start -> cpu_reset high 2 cycles, then run=1; with no halt, done=1 and timeout=1 after cycle_count reaches 30.
REQ-034 HALT_W=3; halt_req=3'b100 at cycle_count=7 -> done=1, halt_src=3'b100, timeout=0, cycle_count=8.
REQ-035 MAX_CYCLES=10; halt_req=1 in the same cycle that cycle_count=9 -> timeout=0, halt_src=1.
REQ-036 reset_n pulsed low mid-RUN at cycle_count=5 -> all outputs at reset values the same cycle, and IDLE holds until start.
REQ-037 Both start and abort in RUN -> IDLE, status kept; then start from DONE -> counter cleared, RESET re-entered.
REQ-038 With RUN_CTRL_SINGLE_STEP_EN defined, step_mode=1 and 3 step pulses -> exactly 3 cpu_ce cycles, cycle_count=3.
